// File: rtl/sensor_ultrassom_multi.sv
// sensor_ultrassom_multi: multi-channel HC-SR04 style ultrasonic ranging unit.
// It fires a trigger pulse on one channel, times the echo on the same channel
// and converts the echo width to whole centimetres while it is being measured.
// It can measure one selected channel or sweep all channels in order.
// Optional build macro: SENSOR_ARREDONDAMENTO_EN. When defined, the result is
// rounded to the nearest centimetre. When undefined, the result is truncated.
module sensor_ultrassom_multi #(
  parameter int N_CANAIS        = 4,
  parameter int CLK_POR_CM      = 2941,
  parameter int LARGURA_TRIGGER = 500,
  parameter int TIMEOUT_CICLOS  = 1_500_000,
  parameter int LARGURA_MEDIDA  = 9,
  localparam int CW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      medir,
  input  logic                      modo,
  input  logic [CW-1:0]             canal_sel,
  input  logic [N_CANAIS-1:0]       echo,
  output logic [N_CANAIS-1:0]       trigger,
  output logic [LARGURA_MEDIDA-1:0] medida,
  output logic [CW-1:0]             canal,
  output logic                      pronto,
  output logic                      timeout,
  output logic                      ocupado,
  output logic [3:0]                db_estado
);

  localparam int TW = (CLK_POR_CM > 1) ? $clog2(CLK_POR_CM) : 1;
  localparam int GW = (LARGURA_TRIGGER > 1) ? $clog2(LARGURA_TRIGGER) : 1;
  localparam int OW = $clog2(TIMEOUT_CICLOS + 1);

  localparam logic [TW-1:0]             TICK_ULT  = TW'(CLK_POR_CM - 1);
  localparam logic [TW-1:0]             TICK_UM   = TW'(1);
  localparam logic [GW-1:0]             TRIG_ULT  = GW'(LARGURA_TRIGGER - 1);
  localparam logic [GW-1:0]             TRIG_UM   = GW'(1);
  localparam logic [OW-1:0]             TO_ULT    = OW'(TIMEOUT_CICLOS - 1);
  localparam logic [OW-1:0]             TO_UM     = OW'(1);
  localparam logic [LARGURA_MEDIDA-1:0] CM_MAX    = {LARGURA_MEDIDA{1'b1}};
  localparam logic [LARGURA_MEDIDA-1:0] CM_UM     = LARGURA_MEDIDA'(1);
  localparam logic [CW-1:0]             CANAL_ULT = CW'(N_CANAIS - 1);
  localparam logic [CW-1:0]             CANAL_UM  = CW'(1);
`ifdef SENSOR_ARREDONDAMENTO_EN
  localparam logic [TW-1:0]             TICK_MEIO = TW'(CLK_POR_CM / 2);
`endif

  typedef enum logic [2:0] {
    ST_INICIAL     = 3'd0,
    ST_PREPARA     = 3'd1,
    ST_TRIGGER     = 3'd2,
    ST_ESPERA_ECHO = 3'd3,
    ST_MEDE        = 3'd4,
    ST_CALCULA     = 3'd5,
    ST_REGISTRA    = 3'd6,
    ST_PROXIMO     = 3'd7
  } estado_t;

  estado_t                   state_q, state_d;
  logic [N_CANAIS-1:0]       echo_s1_q, echo_s2_q, echo_s3_q;
  logic                      modo_q, modo_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic [TW-1:0]             tick_q, tick_d;
  logic [LARGURA_MEDIDA-1:0] cm_q, cm_d;
  logic [OW-1:0]             to_cnt_q, to_cnt_d;
  logic [GW-1:0]             trig_cnt_q, trig_cnt_d;

  logic [N_CANAIS-1:0]       trigger_q, trigger_d;
  logic [LARGURA_MEDIDA-1:0] medida_q, medida_d;
  logic [CW-1:0]             canal_q, canal_d;
  logic                      pronto_q, pronto_d;
  logic                      timeout_q, timeout_d;
  logic                      ocupado_q, ocupado_d;

  // Edge detection only looks at the active channel; s3 is the previous s2.
  logic rise_s, fall_s, tmo_s, to_flag_s, cont_sweep_s;
  assign rise_s       = echo_s2_q[ch_q] & ~echo_s3_q[ch_q];
  assign fall_s       = ~echo_s2_q[ch_q] & echo_s3_q[ch_q];
  assign tmo_s        = (to_cnt_q == TO_ULT);
  assign to_flag_s    = tmo_s && ((state_q == ST_ESPERA_ECHO) || (state_q == ST_MEDE));
  assign cont_sweep_s = modo_q && (ch_q != CANAL_ULT);

  // Two-flop echo synchroniser plus one history stage for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
      echo_s3_q <= '0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; the timeout has priority over echo edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INICIAL:     if (medir) state_d = ST_PREPARA; else state_d = ST_INICIAL;
      ST_PREPARA:     state_d = ST_TRIGGER;
      ST_TRIGGER:     if (trig_cnt_q == TRIG_ULT) state_d = ST_ESPERA_ECHO; else state_d = ST_TRIGGER;
      ST_ESPERA_ECHO: if (tmo_s) state_d = ST_REGISTRA;
                      else if (rise_s) state_d = ST_MEDE;
                      else state_d = ST_ESPERA_ECHO;
      ST_MEDE:        if (tmo_s) state_d = ST_REGISTRA;
                      else if (fall_s) state_d = ST_CALCULA;
                      else state_d = ST_MEDE;
      ST_CALCULA:     state_d = ST_REGISTRA;
      ST_REGISTRA:    state_d = ST_PROXIMO;
      ST_PROXIMO:     if (cont_sweep_s) state_d = ST_PREPARA; else state_d = ST_INICIAL;
      default:        state_d = ST_INICIAL;
    endcase
  end

  // Datapath next values: channel selection, trigger/timeout counters and the
  // on-the-fly tick-to-centimetre conversion.
  always_comb begin
    modo_d     = modo_q;
    ch_d       = ch_q;
    tick_d     = tick_q;
    cm_d       = cm_q;
    to_cnt_d   = to_cnt_q;
    trig_cnt_d = trig_cnt_q;
    case (state_q)
      ST_INICIAL: begin
        if (medir) begin
          modo_d = modo;
          if (modo) ch_d = '0; else ch_d = canal_sel;
        end else begin
          modo_d = modo_q;
        end
      end
      ST_PREPARA: begin
        tick_d     = '0;
        cm_d       = '0;
        to_cnt_d   = '0;
        trig_cnt_d = '0;
      end
      ST_TRIGGER: trig_cnt_d = trig_cnt_q + TRIG_UM;
      ST_ESPERA_ECHO: to_cnt_d = to_cnt_q + TO_UM;
      ST_MEDE: begin
        to_cnt_d = to_cnt_q + TO_UM;
        // The fall cycle is counted too, so the count equals the echo width.
        if (tick_q == TICK_ULT) begin
          tick_d = '0;
          if (cm_q != CM_MAX) cm_d = cm_q + CM_UM; else cm_d = cm_q;
        end else begin
          tick_d = tick_q + TICK_UM;
        end
      end
      ST_CALCULA: begin
`ifdef SENSOR_ARREDONDAMENTO_EN
        if ((tick_q >= TICK_MEIO) && (cm_q != CM_MAX)) cm_d = cm_q + CM_UM;
        else cm_d = cm_q;
`else
        cm_d = cm_q;
`endif
      end
      ST_REGISTRA: cm_d = cm_q;
      ST_PROXIMO: if (cont_sweep_s) ch_d = ch_q + CANAL_UM; else ch_d = ch_q;
      default: ch_d = ch_q;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    trigger_d = '0;
    medida_d  = medida_q;
    canal_d   = canal_q;
    timeout_d = timeout_q;
    pronto_d  = (state_d == ST_REGISTRA);
    if (state_d == ST_TRIGGER) trigger_d[ch_q] = 1'b1; else trigger_d = '0;
    if (state_d == ST_REGISTRA) begin
      // cm_d already carries the rounding decided in CALCULA.
      if (to_flag_s) medida_d = CM_MAX; else medida_d = cm_d;
      canal_d   = ch_q;
      timeout_d = to_flag_s;
    end else begin
      medida_d = medida_q;
    end
    // Busy drops together with the final PROXIMO so it falls right after pronto.
    if ((state_d == ST_INICIAL) || ((state_d == ST_PROXIMO) && !cont_sweep_s)) ocupado_d = 1'b0;
    else ocupado_d = 1'b1;
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      modo_q     <= 1'b0;
      ch_q       <= '0;
      tick_q     <= '0;
      cm_q       <= '0;
      to_cnt_q   <= '0;
      trig_cnt_q <= '0;
      trigger_q  <= '0;
      medida_q   <= '0;
      canal_q    <= '0;
      pronto_q   <= 1'b0;
      timeout_q  <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      modo_q     <= modo_d;
      ch_q       <= ch_d;
      tick_q     <= tick_d;
      cm_q       <= cm_d;
      to_cnt_q   <= to_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      trigger_q  <= trigger_d;
      medida_q   <= medida_d;
      canal_q    <= canal_d;
      pronto_q   <= pronto_d;
      timeout_q  <= timeout_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign trigger   = trigger_q;
  assign medida    = medida_q;
  assign canal     = canal_q;
  assign pronto    = pronto_q;
  assign timeout   = timeout_q;
  assign ocupado   = ocupado_q;
  assign db_estado = {1'b0, state_q};

endmodule

// File: tb/tb_sensor_ultrassom_multi.sv
// Testbench for sensor_ultrassom_multi, built with scaled-down timing so that
// one centimetre is 10 cycles. A second instance with a 6-bit result checks
// saturation on every measurement. Expected results are queued when echoes are
// driven and compared when pronto appears.
module tb_sensor_ultrassom_multi;

  localparam int N  = 4;
  localparam int C  = 10;
  localparam int L  = 5;
  localparam int T  = 2500;
`ifdef SENSOR_ARREDONDAMENTO_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       medir = 1'b0;
  logic       modo  = 1'b0;
  logic [1:0] canal_sel = 2'd0;
  logic [3:0] echo = 4'd0;

  logic [3:0] trigger_a, trigger_b;
  logic [8:0] medida_a;
  logic [5:0] medida_b;
  logic [1:0] canal_a, canal_b;
  logic       pronto_a, pronto_b, timeout_a, timeout_b, ocupado_a, ocupado_b;
  logic [3:0] db_a, db_b;

  sensor_ultrassom_multi #(.N_CANAIS(N), .CLK_POR_CM(C), .LARGURA_TRIGGER(L),
                           .TIMEOUT_CICLOS(T), .LARGURA_MEDIDA(9)) dut_a (
    .clock(clock), .reset(reset), .medir(medir), .modo(modo), .canal_sel(canal_sel),
    .echo(echo), .trigger(trigger_a), .medida(medida_a), .canal(canal_a),
    .pronto(pronto_a), .timeout(timeout_a), .ocupado(ocupado_a), .db_estado(db_a));

  sensor_ultrassom_multi #(.N_CANAIS(N), .CLK_POR_CM(C), .LARGURA_TRIGGER(L),
                           .TIMEOUT_CICLOS(T), .LARGURA_MEDIDA(6)) dut_b (
    .clock(clock), .reset(reset), .medir(medir), .modo(modo), .canal_sel(canal_sel),
    .echo(echo), .trigger(trigger_b), .medida(medida_b), .canal(canal_b),
    .pronto(pronto_b), .timeout(timeout_b), .ocupado(ocupado_b), .db_estado(db_b));

  always #5 clock = ~clock;

  typedef struct {int medida; int canal; int tmo;} exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;
  int   trig_rises = 0;
  logic [3:0] trig_prev = 4'd0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cm_of(input int w, input int maxv);
    int e;
    e = w / C;
    if (ROUND && ((w % C) >= (C / 2))) e++;
    if (e > maxv) e = maxv;
    return e;
  endfunction

  // Scoreboard: compare every result strobe against the queued expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (pronto_a) begin
        if (q_a.size() == 0) check("pronto_a_unexpected", 1, 0);
        else begin
          ea = q_a.pop_front();
          check("medida_a", medida_a, ea.medida);
          check("canal_a", canal_a, ea.canal);
          check("timeout_a", timeout_a, ea.tmo);
        end
      end
      if (pronto_b) begin
        if (q_b.size() == 0) check("pronto_b_unexpected", 1, 0);
        else begin
          eb = q_b.pop_front();
          check("medida_b_sat", medida_b, eb.medida);
          check("timeout_b", timeout_b, eb.tmo);
        end
      end
      for (int i = 0; i < N; i++) if (trigger_a[i] && !trig_prev[i]) trig_rises++;
      trig_prev = trigger_a;
    end else begin
      trig_prev = 4'd0;
    end
  end

  task automatic push_meas(input int w, input int ch);
    q_a.push_back('{cm_of(w, 511), ch, 0});
    q_b.push_back('{cm_of(w, 63), ch, 0});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_trigger"}, trigger_a, 0);
    check({tag, "_medida"}, medida_a, 0);
    check({tag, "_canal"}, canal_a, 0);
    check({tag, "_pronto"}, pronto_a, 0);
    check({tag, "_timeout"}, timeout_a, 0);
    check({tag, "_ocupado"}, ocupado_a, 0);
    check({tag, "_estado"}, db_a, 0);
  endtask

  task automatic start(input bit m, input int ch);
    @(negedge clock);
    modo = m;
    canal_sel = ch[1:0];
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    check("ocupado_rise", ocupado_a, 1);
  endtask

  task automatic wait_trig(input int ch);
    int n = 0;
    while (!trigger_a[ch] && n < 200) begin @(negedge clock); n++; end
    check("trig_seen", trigger_a[ch], 1);
    check("trig_onehot", trigger_a, 1 << ch);
  endtask

  // Returns at the first negedge with the trigger low (first ESPERA_ECHO cycle).
  task automatic wait_trig_end(input int ch);
    int hi = 0;
    while (trigger_a[ch] && hi < 100) begin @(negedge clock); hi++; end
    check("trig_width", hi, L);
  endtask

  task automatic do_echo(input int ch, input int w, input bit noise);
    wait_trig(ch);
    wait_trig_end(ch);
    if (noise) begin
      echo[(ch + 1) % N] = 1'b1;
      repeat (20) @(negedge clock);
      echo[(ch + 1) % N] = 1'b0;
    end
    repeat (3) @(negedge clock);
    echo[ch] = 1'b1;
    repeat (w) @(negedge clock);
    echo[ch] = 1'b0;
    push_meas(w, ch);
  endtask

  task automatic wait_pronto(output int n);
    n = 0;
    while (!pronto_a && n < 4000) begin @(negedge clock); n++; end
    check("pronto_seen", pronto_a, 1);
  endtask

  int n;
  int sweep_w[4] = '{1701, 1003, 747, 200};

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b1;

    // Single mode, channel 0, 100 cm
    start(1'b0, 0);
    do_echo(0, 1003, 1'b0);
    wait_pronto(n);
    check("ocupado_at_pronto", ocupado_a, 1);
    @(negedge clock);
    check("pronto_pulse", pronto_a, 0);
    check("ocupado_fall", ocupado_a, 0);

    // Single mode, channel 2, 74.7 cm, with noise on an inactive channel
    start(1'b0, 2);
    do_echo(2, 747, 1'b1);
    wait_pronto(n);
    @(negedge clock);
    check("ocupado_fall2", ocupado_a, 0);

    // Sweep over all four channels
    start(1'b1, 3);
    for (int ch = 0; ch < N; ch++) begin
      do_echo(ch, sweep_w[ch], 1'b0);
      wait_pronto(n);
      @(negedge clock);
      check("sweep_pronto_pulse", pronto_a, 0);
      check("sweep_ocupado", ocupado_a, (ch < N - 1) ? 1 : 0);
    end

    // Timeout on channel 1: pronto exactly T cycles after ESPERA_ECHO entry
    start(1'b0, 1);
    wait_trig(1);
    wait_trig_end(1);
    q_a.push_back('{511, 1, 1});
    q_b.push_back('{63, 1, 1});
    wait_pronto(n);
    check("tmo_latency", n, T);
    @(negedge clock);
    check("ocupado_fall_tmo", ocupado_a, 0);

    // Asynchronous reset in the middle of MEDE
    start(1'b0, 0);
    wait_trig(0);
    wait_trig_end(0);
    repeat (2) @(negedge clock);
    echo[0] = 1'b1;
    repeat (30) @(negedge clock);
    check("state_mede", db_a, 4);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_mid");
    echo[0] = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Measurement after reset, with a second medir while busy
    start(1'b0, 3);
    do_echo(3, 1003, 1'b0);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_pronto(n);
    repeat (40) @(negedge clock);
    check("ocupado_idle", ocupado_a, 0);
    check("trigger_count", trig_rises, 9);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
